// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction and data memory request/ack bundle
interface multicycle_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle sequencer owning pc, ir and memory handshakes
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_ctrl_if.master        mem,
    output logic [31:0]              ir,
    input  logic                     dec_rf_we,
    input  logic                     dec_is_load,
    input  logic                     dec_is_store,
    input  logic                     dec_illegal,
    input  logic [31:0]              alu_result,
    input  logic                     br_taken,
    input  logic [31:0]              br_target,
    input  logic [31:0]              store_data,
    output logic                     rf_we,
    output logic [31:0]              rf_wdata,
    output logic [31:0]              pc,
    output logic                     halt,
    output logic [31:0]              instret
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] ex_result_q, ex_result_d;
    logic        take_q, take_d;
    logic [31:0] target_q, target_d;
    logic [31:0] mem_data_q, mem_data_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        instret_d   = instret_q;
        ex_result_d = ex_result_q;
        take_d      = take_q;
        target_d    = target_q;
        mem_data_d  = mem_data_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = dec_illegal ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                ex_result_d = alu_result;
                take_d      = br_taken;
                target_d    = br_target;
                // A misaligned taken target traps before pc is touched.
                if (br_taken && (br_target[1:0] != 2'b00)) begin
                    state_d = S_HALT;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem.dmem_ack) begin
                    if (dec_is_load) begin
                        mem_data_d = mem.dmem_rdata;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d      = take_q ? target_q : pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            instret_q   <= '0;
            ex_result_q <= '0;
            take_q      <= 1'b0;
            target_q    <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            instret_q   <= instret_d;
            ex_result_q <= ex_result_d;
            take_q      <= take_d;
            target_q    <= target_d;
            mem_data_q  <= mem_data_d;
        end
    end

    // Strobes are qualified by rst_n so a reset cycle never issues a request or a write.
    assign mem.imem_req   = rst_n && (state_q == S_FETCH);
    assign mem.imem_addr  = pc_q;
    assign mem.dmem_req   = rst_n && (state_q == S_MEM);
    assign mem.dmem_we    = mem.dmem_req && dec_is_store;
    assign mem.dmem_addr  = (state_q == S_MEM) ? ex_result_q : '0;
    assign mem.dmem_wdata = (state_q == S_MEM) ? store_data : '0;

    assign rf_we    = rst_n && (state_q == S_WB) && dec_rf_we && !dec_is_store;
    assign rf_wdata = (state_q == S_WB) ? (dec_is_load ? mem_data_q : ex_result_q) : '0;
    assign ir       = ir_q;
    assign pc       = pc_q;
    assign halt     = (state_q == S_HALT);
    assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with random instruction stream
module tb_multicycle_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int T_FETCH = 0;
    localparam int T_DMEM  = 1;
    localparam int T_RF    = 2;
    localparam int T_HALT  = 3;

    typedef struct {
        int          tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        dec_rf_we, dec_is_load, dec_is_store, dec_illegal;
    logic [31:0] alu_result;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] store_data;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        halt;
    logic [31:0] instret;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem          (bus),
        .ir           (ir),
        .dec_rf_we    (dec_rf_we),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_illegal  (dec_illegal),
        .alu_result   (alu_result),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .store_data   (store_data),
        .rf_we        (rf_we),
        .rf_wdata     (rf_wdata),
        .pc           (pc),
        .halt         (halt),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    int          m_prev_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic pop_exp(input int tag, input string name, output exp_t e, output bit ok);
        total++;
        ok = 1'b0;
        e.tag = -1; e.a = '0; e.b = '0; e.c = '0; e.d = -1;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: got unexpected event expected no event", name);
        end else begin
            e = exp_q.pop_front();
            if (e.tag != tag) begin
                bad++;
                $display("FAIL %s: got event kind %0d expected kind %0d", name, tag, e.tag);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a handshake or strobes an output.
    initial begin
        int          cyc;
        int          last;
        bit          ir_pend;
        logic [31:0] ir_exp;
        bit          prev_halt;
        exp_t        e;
        bit          ok;
        cyc = 0; last = -1; ir_pend = 0; ir_exp = '0; prev_halt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                last = -1; ir_pend = 0; prev_halt = 0;
            end else begin
                if (ir_pend) begin
                    chk("ir_load", ir, ir_exp);
                    ir_pend = 0;
                end
                if (bus.imem_req && bus.imem_ack) begin
                    pop_exp(T_FETCH, "fetch_event", e, ok);
                    if (ok) begin
                        chk("fetch_addr", bus.imem_addr, e.a);
                        chk("instret", instret, e.b);
                        if (e.d >= 0 && last >= 0) chk("instr_latency", 32'(cyc - last), 32'(e.d));
                        ir_exp = e.c; ir_pend = 1;
                    end
                    last = cyc;
                end
                if (bus.dmem_req && bus.dmem_ack) begin
                    pop_exp(T_DMEM, "dmem_event", e, ok);
                    if (ok) begin
                        chk("dmem_addr", bus.dmem_addr, e.a);
                        chk("dmem_we", 32'(bus.dmem_we), e.b);
                        chk("dmem_wdata", bus.dmem_wdata, e.c);
                    end
                end
                if (rf_we) begin
                    pop_exp(T_RF, "rf_write_event", e, ok);
                    if (ok) chk("rf_wdata", rf_wdata, e.a);
                end
                if (halt && !prev_halt) begin
                    pop_exp(T_HALT, "halt_event", e, ok);
                    if (ok) chk("halt_pc", pc, e.a);
                end
                prev_halt = halt;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rst_imem_req", 32'(bus.imem_req), 0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 0);
        chk("rst_dmem_we", 32'(bus.dmem_we), 0);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instret", instret, 0);
        rst_n = 1'b1;
        m_pc = RST_PC;
        m_instret = '0;
        m_prev_base = -1;
    endtask

    // kind: 0 alu/branch/jump, 1 load, 2 store, 3 illegal
    task automatic do_instr(input int kind, input logic rfwe, input logic [31:0] alu, input logic bt,
                            input logic [31:0] tgt, input logic [31:0] sd, input logic [31:0] ld,
                            input int fw, input int dw, input bit rst_mid);
        exp_t        e;
        logic [31:0] word;
        logic [31:0] fpc;
        bit          traps;
        bit          is_mem;
        int          n;
        word   = $urandom;
        fpc    = m_pc;
        is_mem = (kind == 1) || (kind == 2);
        traps  = (kind == 3) || (bt && (tgt[1:0] != 2'b00));

        e.tag = T_FETCH; e.a = m_pc; e.b = m_instret; e.c = word;
        e.d = (m_prev_base < 0) ? -1 : m_prev_base + fw;
        exp_q.push_back(e);
        if (traps) begin
            e.tag = T_HALT; e.a = m_pc; e.b = '0; e.c = '0; e.d = 0;
            exp_q.push_back(e);
        end else if (!rst_mid) begin
            if (is_mem) begin
                e.tag = T_DMEM; e.a = alu; e.b = (kind == 2) ? 32'd1 : 32'd0; e.c = sd; e.d = 0;
                exp_q.push_back(e);
            end
            if (rfwe && kind != 2) begin
                e.tag = T_RF; e.a = (kind == 1) ? ld : alu; e.b = '0; e.c = '0; e.d = 0;
                exp_q.push_back(e);
            end
            m_pc = bt ? tgt : m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
            m_prev_base = is_mem ? 5 + dw : 4;
        end

        n = 0;
        while (!bus.imem_req && n < 64) begin @(posedge clk); #1; n++; end
        chk("fetch_req_seen", 32'(bus.imem_req), 1);
        for (int i = 0; i < fw; i++) begin
            chk("stall_addr", bus.imem_addr, fpc);
            bus.dmem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.dmem_ack  = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_rdata = word;
        dec_illegal   = (kind == 3);
        dec_is_load   = (kind == 1);
        dec_is_store  = (kind == 2);
        dec_rf_we     = rfwe;
        alu_result    = alu;
        br_taken      = bt;
        br_target     = tgt;
        store_data    = sd;
        @(posedge clk); #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;

        if (traps) begin
            n = 0;
            while (!halt && n < 10) begin @(posedge clk); #1; n++; end
            chk("halt_reached", 32'(halt), 1);
            for (int i = 0; i < 3; i++) begin
                bus.imem_ack = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk("halted_imem_req", 32'(bus.imem_req), 0);
                chk("halted_dmem_req", 32'(bus.dmem_req), 0);
                chk("halted_rf_we", 32'(rf_we), 0);
                chk("halted_pc", pc, fpc);
            end
            do_reset();
        end else if (is_mem) begin
            n = 0;
            while (!bus.dmem_req && n < 16) begin @(posedge clk); #1; n++; end
            chk("dmem_req_seen", 32'(bus.dmem_req), 1);
            if (rst_mid) begin
                @(posedge clk); #1;
                chk("mid_dmem_addr", bus.dmem_addr, alu);
                do_reset();
            end else begin
                for (int i = 0; i < dw; i++) begin
                    bus.imem_ack = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.imem_ack   = 1'b0;
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = ld;
                @(posedge clk); #1;
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = $urandom;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        dec_rf_we = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0; dec_illegal = 1'b0;
        alu_result = '0; br_taken = 1'b0; br_target = '0; store_data = '0;
        m_pc = RST_PC; m_instret = '0; m_prev_base = -1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir", ir, 0);
        do_reset();

        do_instr(0, 1'b1, 32'd7,          1'b0, 32'h0,         32'h0,  32'h0,         0, 0, 1'b0);
        do_instr(0, 1'b1, 32'h1234_5678,  1'b0, 32'h0,         32'h0,  32'h0,         3, 0, 1'b0);
        do_instr(1, 1'b1, 32'h0000_2000,  1'b0, 32'h0,         32'h0,  32'hDEAD_BEEF, 0, 2, 1'b0);
        do_instr(2, 1'b1, 32'h0000_3000,  1'b0, 32'h0,         32'h55, 32'h0,         0, 0, 1'b0);
        do_instr(0, 1'b0, 32'h0,          1'b1, 32'h40,        32'h0,  32'h0,         1, 0, 1'b0);
        do_instr(0, 1'b1, 32'h44,         1'b1, 32'hFFFF_FFFC, 32'h0,  32'h0,         0, 0, 1'b0);
        do_instr(0, 1'b1, 32'h99,         1'b0, 32'h0,         32'h0,  32'h0,         0, 0, 1'b0);
        do_instr(0, 1'b1, 32'h5,          1'b0, 32'h0,         32'h0,  32'h0,         0, 0, 1'b0);
        do_instr(0, 1'b0, 32'h0,          1'b1, 32'h42,        32'h0,  32'h0,         0, 0, 1'b0);
        do_instr(3, 1'b1, 32'h0,          1'b0, 32'h0,         32'h0,  32'h0,         0, 0, 1'b0);
        do_instr(1, 1'b1, 32'h0000_4000,  1'b0, 32'h0,         32'h0,  32'h1,         0, 3, 1'b1);

        for (int k = 0; k < 200; k++) begin
            int          r;
            int          kind;
            logic        bt;
            logic [31:0] tgt;
            bit          rmid;
            r    = $urandom_range(0, 19);
            kind = (r < 10) ? 0 : (r < 14) ? 1 : (r < 18) ? 2 : (r == 18) ? 3 : 0;
            bt   = (kind == 0) && ($urandom_range(0, 2) == 0);
            tgt  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            rmid = (kind == 1 || kind == 2) && ($urandom_range(0, 29) == 0);
            do_instr(kind, 1'($urandom_range(0, 1)), $urandom, bt, tgt, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3), rmid);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
